spram_pcm_player: RTL and testbench

Playback stage downstream of the SPRAM loader. Once the loader asserts `ram_ready`, this block drives the SPRAM read address, fetches 8-bit unsigned PCM samples from the low byte of each 16-bit word, and renders them as a fixed-period PWM output. It emits a one-cycle `pw_end` pulse at every PWM period boundary, which the loader uses to advance its fread offset. Sample fetch is double-buffered, so there are no idle periods between samples.

---
 rtl/spram_pcm_player.sv | 161 ++++++++++++++++
 tb/tb_spram_pcm_player.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spram_pcm_player.sv
// SPRAM PCM player: fetches 8-bit samples from the SPRAM low byte and renders them as PWM.
// Define SPRAM_PCM_PLAYER_LOOP_EN to loop forever instead of stopping after DEPTH samples.
module spram_pcm_player #(
  parameter int unsigned DEPTH    = 8192,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ready_i,
  output logic [13:0] address_o,
  input  logic [15:0] dataout_i,
  output logic        pwm_out_o,
  output logic        pw_end_o,
  output logic        playing_o,
  output logic        done_o
);
  localparam logic [13:0]     LastAddr = 14'(DEPTH - 1);
  localparam int unsigned     PreW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(PRESCALE - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StPlay, StStop} state_e;

  state_e          state_q, state_d;
  logic [13:0]     addr_q, addr_d, addr_inc;
  logic [7:0]      pcnt_q, pcnt_d, cur_q, cur_d, nxt_q, nxt_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            nxt_ok_q, nxt_ok_d, second_q, second_d, pf_q, pf_d, pwm_q, pwm_d;
  logic            tick, period_end, cap_nxt, load_cur, last_play;
  logic            unused_data_hi;

  assign unused_data_hi = ^dataout_i[15:8];
  assign addr_inc   = (addr_q == LastAddr) ? 14'd0 : addr_q + 14'd1;
  assign tick       = (pre_q == PreMax);
  assign period_end = (state_q == StPlay) && tick && (pcnt_q == 8'hFF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      pcnt_q   <= '0;
      pre_q    <= '0;
      cur_q    <= '0;
      nxt_q    <= '0;
      nxt_ok_q <= 1'b0;
      second_q <= 1'b0;
      pf_q     <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pcnt_q   <= pcnt_d;
      pre_q    <= pre_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      nxt_ok_q <= nxt_ok_d;
      second_q <= second_d;
      pf_q     <= pf_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pcnt_d   = pcnt_q;
    pre_d    = pre_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    nxt_ok_d = nxt_ok_q;
    second_d = second_q;
    pf_d     = pf_q;
    pwm_d    = 1'b0;
    cap_nxt  = 1'b0;
    load_cur = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ram_ready_i) state_d = StFetch;
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        addr_d = addr_inc;
        if (!second_q) begin
          cur_d    = dataout_i[7:0];
          second_d = 1'b1;
          state_d  = StFetch;
        end else begin
          nxt_d    = dataout_i[7:0];
          nxt_ok_d = 1'b1;
          cap_nxt  = 1'b1;
          state_d  = StPlay;
        end
      end
      StPlay: begin
        pwm_d = (pcnt_q < cur_q);
        pre_d = tick ? '0 : pre_q + PreW'(1);
        if (tick) pcnt_d = pcnt_q + 8'd1;
        // Background prefetch: pf_q marks the cycle the SPRAM samples address, capture follows.
        if (pf_q) begin
          pf_d = 1'b0;
        end else if (!nxt_ok_q) begin
          nxt_d    = dataout_i[7:0];
          nxt_ok_d = 1'b1;
          addr_d   = addr_inc;
          cap_nxt  = 1'b1;
        end
        if (period_end) begin
          if (last_play) begin
            state_d = StStop;
            pwm_d   = 1'b0;
          end else begin
            cur_d    = nxt_q;
            nxt_ok_d = 1'b0;
            pf_d     = 1'b1;
            load_cur = 1'b1;
          end
        end
      end
      StStop: ;
      default: state_d = StIdle;
    endcase
    // Losing the read port abandons playback from any active state.
    if (!ram_ready_i && state_q != StIdle) begin
      state_d  = StIdle;
      pwm_d    = 1'b0;
      addr_d   = '0;
      nxt_ok_d = 1'b0;
      pcnt_d   = '0;
      pre_d    = '0;
      pf_d     = 1'b0;
      second_d = 1'b0;
      cap_nxt  = 1'b0;
      load_cur = 1'b0;
    end
  end

`ifdef SPRAM_PCM_PLAYER_LOOP_EN
  logic unused_strobes;
  assign unused_strobes = cap_nxt ^ load_cur;
  assign last_play      = 1'b0;
  assign done_o         = 1'b0;
`else
  // Tag the sample fetched from DEPTH-1 so the period playing it is the last one.
  logic cur_last_q, nxt_last_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == StIdle) begin
      cur_last_q <= 1'b0;
      nxt_last_q <= 1'b0;
    end else begin
      if (cap_nxt) nxt_last_q <= (addr_q == LastAddr);
      if (load_cur) cur_last_q <= nxt_last_q;
    end
  end
  assign last_play = cur_last_q;
  assign done_o    = (state_q == StStop);
`endif

  assign address_o = addr_q;
  assign pwm_out_o = pwm_q;
  assign playing_o = (state_q == StPlay);
  assign pw_end_o  = period_end && ram_ready_i && !rst_i;
endmodule

// File: tb/tb_spram_pcm_player.sv
// Bench for spram_pcm_player: two instances (PRESCALE 1 and 3) with SPRAM models,
// checked against a period-level playback model.
module tb_spram_pcm_player;
  localparam int DepA = 4;
  localparam int PreA = 1;
  localparam int DepB = 5;
  localparam int PreB = 3;
`ifdef SPRAM_PCM_PLAYER_LOOP_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy [2];
  logic [13:0] addr_a, addr_b;
  logic [15:0] dout_a, dout_b;
  logic        pwm_a, pwm_b, pwe_a, pwe_b, play_a, play_b, done_a, done_b;
  logic [7:0]  mem [2][16];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // One-cycle-latency SPRAM models; high byte is junk the player must ignore.
  always @(posedge clk) begin
    dout_a <= {~mem[0][addr_a[3:0]], mem[0][addr_a[3:0]]};
    dout_b <= {~mem[1][addr_b[3:0]], mem[1][addr_b[3:0]]};
  end

  spram_pcm_player #(.DEPTH(DepA), .PRESCALE(PreA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .ram_ready_i(rdy[0]), .address_o(addr_a), .dataout_i(dout_a),
    .pwm_out_o(pwm_a), .pw_end_o(pwe_a), .playing_o(play_a), .done_o(done_a)
  );

  spram_pcm_player #(.DEPTH(DepB), .PRESCALE(PreB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .ram_ready_i(rdy[1]), .address_o(addr_b), .dataout_i(dout_b),
    .pwm_out_o(pwm_b), .pw_end_o(pwe_b), .playing_o(play_b), .done_o(done_b)
  );

  function automatic logic [13:0] o_addr(input int d);
    return (d == 0) ? addr_a : addr_b;
  endfunction
  function automatic logic o_pwm(input int d);
    return (d == 0) ? pwm_a : pwm_b;
  endfunction
  function automatic logic o_pwe(input int d);
    return (d == 0) ? pwe_a : pwe_b;
  endfunction
  function automatic logic o_play(input int d);
    return (d == 0) ? play_a : play_b;
  endfunction
  function automatic logic o_done(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise ram_ready and follow playback for nper periods. Model: startup fetches addresses 0,1
  // (address 2 once playing), each period lasts 256*PRESCALE cycles with duty sample*PRESCALE,
  // and each period end (except the final one when not looping) advances the address 3 steps later.
  task automatic play_check(input int d, input int nper, output int ea);
    int dep, pre, t, npw, last_pw, hi, inc_at, limit, kclosed;
    bit close_pend;
    dep = (d == 0) ? DepA : DepB;
    pre = (d == 0) ? PreA : PreB;
    t = 0; npw = 0; last_pw = 4; hi = 0; inc_at = -1; kclosed = 0; close_pend = 1'b0; ea = 0;
    limit = 8 + (nper + 1) * 256 * pre;
    rdy[d] = 1'b1;
    while (kclosed < nper && t < limit) begin
      step();
      t++;
      if (t == 3 || t == 5 || t == inc_at) ea = (ea + 1 == dep) ? 0 : ea + 1;
      chk("addr", 32'(o_addr(d)), 32'(ea));
      if (t == 4) chk("startup_not_yet", 32'(o_play(d)), 0);
      if (t == 5) chk("startup_playing", 32'(o_play(d)), 1);
      hi += int'(o_pwm(d));
      if (close_pend) begin
        chk("duty", 32'(hi), 32'(int'(mem[d][kclosed % dep]) * pre));
        hi = 0;
        kclosed++;
        close_pend = 1'b0;
      end
      if (o_pwe(d)) begin
        npw++;
        chk("pw_gap", 32'(t - last_pw), 32'(256 * pre));
        chk("pw_in_play", 32'(o_play(d)), 1);
        last_pw = t;
        close_pend = 1'b1;
        if (Loop || npw < dep) inc_at = t + 3;
      end
    end
    chk("periods", 32'(kclosed), 32'(nper));
  endtask

  initial begin
    int ea, bad;
    rst = 1'b1;
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = 8'($urandom);
      mem[1][i] = 8'($urandom);
    end
    mem[0][0] = 8'h00;
    mem[0][1] = 8'h80;
    mem[0][2] = 8'hFF;
    repeat (3) step();
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_pwm", 32'(pwm_a), 0);
    chk("rst_pw_end", 32'(pwe_a), 0);
    chk("rst_playing", 32'(play_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    rst = 1'b0;
    step();
    chk("idle_playing", 32'(play_a), 0);

    // Full playback on A: 0x00, 0x80, 0xFF, random.
    play_check(0, Loop ? DepA + 3 : DepA, ea);
`ifdef SPRAM_PCM_PLAYER_LOOP_EN
    chk("loop_done", 32'(done_a), 0);
    chk("loop_playing", 32'(play_a), 1);
`else
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (pwe_a || pwm_a || !done_a || play_a || addr_a != 14'(ea)) bad++;
    end
    chk("stop_quiet", 32'(bad), 0);
    chk("stop_done", 32'(done_a), 1);
    chk("stop_addr", 32'(addr_a), 32'(ea));
`endif
    rdy[0] = 1'b0;
    step();
    chk("a_idle_addr", 32'(addr_a), 0);
    chk("a_idle_done", 32'(done_a), 0);
    chk("a_idle_playing", 32'(play_a), 0);

    // Random samples, PRESCALE 3.
    play_check(1, 2, ea);
    rdy[1] = 1'b0;
    step();
    chk("b_idle_addr", 32'(addr_b), 0);
    chk("b_idle_pwm", 32'(pwm_b), 0);

    // Drop ram_ready on the period-end cycle: pw_end must vanish, then restart cleanly.
    rdy[1] = 1'b1;
    repeat (4 + 256 * PreB) step();
    chk("b_pw_end_before_drop", 32'(pwe_b), 1);
    rdy[1] = 1'b0;
    #1;
    chk("b_pw_end_dropped", 32'(pwe_b), 0);
    step();
    chk("b_drop_addr", 32'(addr_b), 0);
    chk("b_drop_pwm", 32'(pwm_b), 0);
    chk("b_drop_playing", 32'(play_b), 0);
    play_check(1, 1, ea);
    rdy[1] = 1'b0;
    step();

    // Reset during a period-end cycle of A.
    rdy[0] = 1'b1;
    repeat (4 + 256 * PreA) step();
    chk("a_pw_end_before_rst", 32'(pwe_a), 1);
    rst = 1'b1;
    #1;
    chk("a_pw_end_in_rst", 32'(pwe_a), 0);
    step();
    chk("mid_rst_addr", 32'(addr_a), 0);
    chk("mid_rst_pwm", 32'(pwm_a), 0);
    chk("mid_rst_pw_end", 32'(pwe_a), 0);
    chk("mid_rst_playing", 32'(play_a), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    rst = 1'b0;
    rdy[0] = 1'b0;
    step();
    chk("post_rst_playing", 32'(play_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
